// File: rtl/sdram_pattern_tester.sv
// sdram_pattern_tester: full-range write/readback tester on the SdramCtrl user port, two passes (pattern, inverted pattern).
module sdram_pattern_tester #(
  parameter int ADDR_W = 24,
  parameter int NUM_WORDS = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [15:0] SEED = 16'hF055,
  parameter int INIT_WAIT = 25000,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              sdram_req,
  input  logic              sdram_ack,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic              sdram_rh_wl,
  output logic [15:0]       sdram_data_w,
  input  logic [15:0]       sdram_data_r,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [7:0]        led
);
  typedef enum logic [2:0] {INIT, IDLE, WR, RD, DONE} state_t;
  state_t state, state_n;
  logic [31:0] init_cnt, to_cnt;
  logic [15:0] i, err_n;
  logic p, ack_ok, last, to_hit, start_ok, mism;
  logic [ADDR_W-1:0] nxt_addr;
  always_comb begin
    start_ok = start && (state == IDLE || state == DONE);
    ack_ok = sdram_ack && sdram_req;
    last = i == 16'(NUM_WORDS - 1);
    to_hit = sdram_req && !sdram_ack && to_cnt == 32'(TIMEOUT - 1);
    mism = ack_ok && state == RD && sdram_data_r != (sdram_addr[15:0] ^ SEED ^ {16{p}});
    err_n = (mism && err_cnt != 16'hFFFF) ? err_cnt + 16'd1 : err_cnt;
    nxt_addr = BASE_ADDR + ADDR_W'(i);
    state_n = state;
    case (state)
      INIT: state_n = init_cnt == 32'(INIT_WAIT - 1) ? IDLE : INIT;
      IDLE, DONE: state_n = start ? WR : state;
      WR: state_n = to_hit ? DONE : (ack_ok && last) ? RD : WR;
      RD: state_n = to_hit ? DONE : (ack_ok && last) ? (p ? DONE : WR) : RD;
      default: state_n = INIT;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= INIT;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_cnt <= '0;
      to_cnt <= '0;
      i <= '0;
      p <= 1'b0;
      sdram_req <= 1'b0;
      sdram_rh_wl <= 1'b1;
      sdram_addr <= '0;
      sdram_data_w <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      timeout <= 1'b0;
      err_cnt <= '0;
      first_err_addr <= '0;
      led <= 8'h00;
    end else begin
      if (state == INIT) init_cnt <= init_cnt + 32'd1;
      if (start_ok) begin
        {i, p, err_cnt, first_err_addr, timeout, done, pass} <= '0;
        busy <= 1'b1;
        led <= 8'h0F;
        sdram_req <= 1'b1;
        sdram_rh_wl <= 1'b0;
        sdram_addr <= BASE_ADDR;
        sdram_data_w <= BASE_ADDR[15:0] ^ SEED;
        to_cnt <= '0;
      end else if (state == WR || state == RD) begin
        // req low here is the single idle cycle after an ack; issue the next word
        if (!sdram_req) begin
          sdram_req <= 1'b1;
          to_cnt <= '0;
          sdram_addr <= nxt_addr;
          sdram_rh_wl <= state == RD;
          sdram_data_w <= nxt_addr[15:0] ^ SEED ^ {16{p}};
        end else if (ack_ok) begin
          sdram_req <= 1'b0;
          sdram_rh_wl <= 1'b1;
          err_cnt <= err_n;
          i <= last ? '0 : i + 16'd1;
          if (mism && err_cnt == '0) first_err_addr <= sdram_addr;
          if (state == RD && last) p <= 1'b1;
          if (state_n == DONE) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= err_n == '0;
            led <= err_n == '0 ? 8'h55 : 8'hAA;
          end
        end else if (to_hit) begin
          sdram_req <= 1'b0;
          sdram_rh_wl <= 1'b1;
          busy <= 1'b0;
          done <= 1'b1;
          timeout <= 1'b1;
          led <= 8'hAA;
        end else to_cnt <= to_cnt + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_sdram_pattern_tester.sv
// tb_sdram_pattern_tester: scoreboarded random-latency memory model driving sdram_pattern_tester.
module tb_sdram_pattern_tester;
  localparam int NW = 4, IW = 20, TO = 16;
  localparam logic [23:0] BASE = 24'h0;
  localparam logic [15:0] SEED = 16'hF055;
  typedef struct packed {
    logic first;
    logic rh;
    logic [23:0] addr;
    logic [15:0] data;
  } txn_t;
  logic clk, reset, start, sdram_req, sdram_ack, sdram_rh_wl, busy, done, pass, timeout;
  logic [23:0] sdram_addr, first_err_addr;
  logic [15:0] sdram_data_w, sdram_data_r, err_cnt;
  logic [7:0] led;
  txn_t sb[$];
  int rd_ptr = 0, n_chk = 0, n_fail = 0, mode = 0, inj_n = 0;
  logic late_ack = 1'b0, inj_any = 1'b0;
  logic [23:0] inj_first = '0;
  logic [15:0] mem [int];

  sdram_pattern_tester #(.ADDR_W(24), .NUM_WORDS(NW), .BASE_ADDR(BASE), .SEED(SEED),
    .INIT_WAIT(IW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
    .sdram_addr(sdram_addr), .sdram_rh_wl(sdram_rh_wl), .sdram_data_w(sdram_data_w),
    .sdram_data_r(sdram_data_r), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_cnt(err_cnt), .first_err_addr(first_err_addr), .led(led));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] exp_d(int i, bit p);
    logic [23:0] a;
    a = BASE + 24'(i);
    return a[15:0] ^ SEED ^ (p ? 16'hFFFF : 16'h0000);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_run(int n);
    txn_t e;
    for (int t = 0; t < n; t++) begin
      e.first = t == 0;
      e.rh = ((t / NW) % 2) == 1;
      e.addr = BASE + 24'(t % NW);
      e.data = e.rh ? 16'h0 : exp_d(t % NW, (t / (2 * NW)) == 1);
      sb.push_back(e);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_req", sdram_req, 0);
    chk("rst_rh_wl", sdram_rh_wl, 1);
    chk("rst_addr", sdram_addr, 0);
    chk("rst_data_w", sdram_data_w, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_first_err", first_err_addr, 0);
    chk("rst_led", led, 8'h00);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_req", sdram_req, 1);
    chk("start_busy", busy, 1);
    chk("start_clear", {err_cnt, 8'(done), 8'(timeout)}, 0);
  endtask

  task automatic wait_done(bit noisy);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done) break;
      start = noisy && ($urandom_range(0, 3) == 0);
    end
    start = 1'b0;
    chk("done_seen", done, 1);
  endtask

  task automatic check_result(int e_err, logic [23:0] e_first, bit e_to);
    bit ok;
    ok = e_err == 0 && !e_to;
    chk("res_busy", busy, 0);
    chk("res_timeout", timeout, e_to);
    chk("res_err_cnt", err_cnt, e_err);
    chk("res_first_err", first_err_addr, e_first);
    chk("res_pass", pass, ok);
    chk("res_led", led, ok ? 8'h55 : 8'hAA);
    chk("sb_drained", rd_ptr, sb.size());
  endtask

  task automatic run_full(int m, bit noisy);
    int e_err;
    logic [23:0] e_first;
    logic [15:0] d;
    mode = m;
    inj_n = 0;
    inj_any = 1'b0;
    inj_first = '0;
    push_run(4 * NW);
    do_start();
    wait_done(noisy);
    e_err = 0;
    e_first = '0;
    if (m == 1)
      for (int p = 0; p < 2; p++)
        for (int i = 0; i < NW; i++) begin
          d = exp_d(i, p == 1);
          if (d[0]) begin
            if (e_err == 0) e_first = BASE + 24'(i);
            e_err++;
          end
        end
    else if (m == 3) begin
      e_err = inj_n;
      e_first = inj_any ? inj_first : '0;
    end
    check_result(e_err, e_first, 1'b0);
  endtask

  initial begin
    int hi;
    bit bad;
    reset = 1'b1;
    start = 1'b1;
    sdram_ack = 1'b0;
    sdram_data_r = '0;
    fork
      begin : responder
        int lat;
        logic [15:0] d;
        lat = -1;
        forever begin
          @(negedge clk);
          sdram_ack = (mode == 2) && late_ack;
          if (reset || !sdram_req) lat = -1;
          else if (mode != 2) begin
            if (lat < 0) lat = (mode == 0) ? 2 : int'($urandom_range(0, 5));
            if (lat == 0) begin
              sdram_ack = 1'b1;
              if (sdram_rh_wl) begin
                d = mem[int'(sdram_addr)];
                if (mode == 1) d[0] = 1'b0;
                if (mode == 3 && $urandom_range(0, 2) == 0) begin
                  d = d ^ 16'($urandom_range(1, 65535));
                  inj_n++;
                  if (!inj_any) begin
                    inj_any = 1'b1;
                    inj_first = sdram_addr;
                  end
                end
                sdram_data_r = d;
              end else mem[int'(sdram_addr)] = sdram_data_w;
              lat = -1;
            end else lat--;
          end
        end
      end
      begin : monitor
        logic prev_req;
        int low;
        txn_t e, held;
        prev_req = 1'b0;
        low = 0;
        forever begin
          @(posedge clk);
          #1;
          if (reset) begin
            prev_req = 1'b0;
            low = 0;
            continue;
          end
          if (sdram_req && !prev_req) begin
            if (rd_ptr >= sb.size()) chk("sb_extra_txn", rd_ptr, sb.size());
            else begin
              e = sb[rd_ptr];
              rd_ptr++;
              chk("txn_rh_wl", sdram_rh_wl, e.rh);
              chk("txn_addr", sdram_addr, e.addr);
              if (!e.rh) chk("txn_data_w", sdram_data_w, e.data);
              if (!e.first) chk("txn_gap", low, 1);
            end
            held = '{1'b0, sdram_rh_wl, sdram_addr, sdram_data_w};
          end else if (sdram_req)
            chk("txn_stable", {sdram_rh_wl, sdram_addr, sdram_data_w}, {held.rh, held.addr, held.data});
          low = sdram_req ? 0 : low + 1;
          prev_req = sdram_req;
        end
      end
    join_none
    repeat (3) @(negedge clk);
    chk_reset_vals();
    reset = 1'b0;
    bad = 1'b0;
    repeat (IW - 1) begin
      @(negedge clk);
      if (sdram_req) bad = 1'b1;
    end
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("init_no_req", {31'b0, bad | sdram_req}, 0);
    chk("idle_led", led, 8'h00);
    run_full(0, 1'b0);
    run_full(0, 1'b1);
    run_full(1, 1'b0);
    repeat (3) run_full(3, 1'b1);
    run_full(0, 1'b0);
    mode = 2;
    push_run(1);
    do_start();
    hi = 0;
    for (int k = 0; k < 100 && sdram_req; k++) begin
      hi++;
      @(negedge clk);
    end
    chk("to_req_cycles", hi, TO);
    chk("to_done", done, 1);
    check_result(0, '0, 1'b1);
    @(negedge clk);
    late_ack = 1'b1;
    @(negedge clk);
    late_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("late_ack_ignored", {8'(sdram_req), 8'(done), 8'(timeout), led}, {8'd0, 8'd1, 8'd1, 8'hAA});
    mode = 0;
    push_run(3);
    do_start();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sdram_req && !sdram_rh_wl && sdram_addr == BASE + 24'd2) break;
    end
    chk("reach_w2", {sdram_req, sdram_addr}, {1'b1, BASE + 24'd2});
    reset = 1'b1;
    #1;
    chk_reset_vals();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (IW + 2) @(negedge clk);
    run_full(0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_pattern_tester.md
# sdram_pattern_tester

Request-side traffic generator and checker that drives the SdramCtrl user port (req/ack/addr/rh_wl/data_w/data_r). It replaces the single-word write/readback test with a full-range test. After power-up it waits out the SDRAM init delay, then runs on a start pulse. Each run writes and reads back a programmable address range in two passes (pattern, then inverted pattern), counting mismatches. Results go to status outputs and the board LEDs.

## Interface
- ADDR_W, 24: SdramCtrl address width (row/col/bank packed).
- NUM_WORDS, 256: words per pass, 1..2^16.
- BASE_ADDR, 24'h0: first address tested.
- SEED, 16'hF055: pattern seed.
- INIT_WAIT, 25000: cycles after reset before start is accepted (400 us at 62.5 MHz).
- TIMEOUT, 1024: max cycles from req high to ack before abort.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle run request.
- sdram_req  out  1  transaction request to SdramCtrl.
- sdram_ack  in  1  one-cycle completion pulse from SdramCtrl.
- sdram_addr  out  ADDR_W  transaction address.
- sdram_rh_wl  out  1  1 = read, 0 = write.
- sdram_data_w  out  16  write data.
- sdram_data_r  in  16  read data, valid in ack cycle when rh_wl=1.
- busy  out  1  run in progress.
- done  out  1  run finished; level until next accepted start.
- pass  out  1  valid when done: err_cnt==0 and no timeout.
- timeout  out  1  run aborted, ack not received.
- err_cnt  out  16  mismatch count, saturating at 16'hFFFF.
- first_err_addr  out  ADDR_W  address of first mismatch in the run.
- led  out  8  status: 8'h00 idle, 8'h0F busy, 8'h55 pass, 8'hAA fail/timeout.

## Operation
- States: INIT, IDLE, WR, RD, DONE.
- Pass counter p is 0 or 1. Word index i runs 0..NUM_WORDS-1.
- Address = BASE_ADDR + i, computed modulo 2^ADDR_W, so wrap is permitted.
- Expected data = (BASE_ADDR+i)[15:0] ^ SEED; this value is bitwise inverted when p=1.
- INIT: counts INIT_WAIT cycles, then goes to IDLE. start is ignored in INIT.
- IDLE: start=1 clears err_cnt, first_err_addr, timeout, done and pass, sets p=0 and i=0, then enters WR.
- WR: issues write i. On ack: if i==NUM_WORDS-1, set i=0 and enter RD; else i++.
- RD: issues read i and compares sdram_data_r against expected in the ack cycle.
  - On mismatch, err_cnt increments, saturating.
  - first_err_addr loads on the first mismatch of the run only.
  - On ack with i==NUM_WORDS-1: if p=0, set p=1, i=0 and enter WR; else enter DONE.
- DONE: done=1. pass=(err_cnt==0). start restarts exactly as from IDLE.
- Timeout:
  - A cycle counter runs while sdram_req=1.
  - On reaching TIMEOUT: req drops, timeout=1, go to DONE with pass=0.
  - A late ack arriving in DONE is ignored.
- start outside IDLE/DONE is ignored. An ack while req=0 is ignored.

## Timing
- Reset values:
  - sdram_req=0, sdram_rh_wl=1, sdram_addr=0, sdram_data_w=0.
  - busy=0, done=0, pass=0, timeout=0, err_cnt=0, first_err_addr=0, led=8'h00.
  - state=INIT.
  - sdram_rh_wl returns to 1 whenever not writing.
- All outputs are registered.
- Request handshake:
  - The cycle after start is sampled, sdram_req=1 with addr, rh_wl and data_w valid.
  - req and all request fields stay stable until ack is sampled high.
  - In the cycle after ack, req=0.
  - The next request asserts the cycle after that, giving exactly one idle cycle between transactions.
- Simultaneous ack and timeout terminal count in the same cycle: the ack wins and the transaction completes.
- err_cnt and first_err_addr update in the cycle after the ack that carried the mismatch.
- done, pass and led update together, one cycle after the final ack.
- busy=1 from the cycle after start until the cycle done rises.
- Reset asserted mid-run forces all reset values immediately, and INIT_WAIT restarts.

## Test plan
- Hold start high from reset through INIT_WAIT-1 cycles -> no sdram_req. Start pulse after INIT -> sdram_req=1 next cycle, rh_wl=0, addr=BASE_ADDR, data_w=16'hF055.
- NUM_WORDS=4 with an ideal model, ack 3 cycles after req:
  - 16 transactions, order W0-3, R0-3, W0-3, R0-3.
  - Data values F055/F054/F057/F056, then 0FAA/0FAB/0FA8/0FA9.
  - Exactly one idle cycle between transactions.
  - done=1, pass=1, err_cnt=0, led=8'h55.
- Model with data_r bit0 stuck at 0, NUM_WORDS=4 -> err_cnt=4, first_err_addr=0, pass=0, led=8'hAA.
- Model never acks, TIMEOUT=16 -> req high exactly 16 cycles, then timeout=1, done=1, led=8'hAA. A late ack changes nothing.
- Reset mid-WR at i=2 -> all outputs at reset values the same cycle. After INIT_WAIT, a new start resumes from i=0.
- Start pulses while busy -> ignored, transaction sequence unchanged. A start in DONE -> clean rerun with counters cleared.
